// File: rtl/d_mem_pkg.sv
// d_mem_pkg
//   Shared types and widths for the data-memory responder slice.
//   state_t : responder FSM encoding (IDLE / WAIT / RESP)
//   WORD_W  : data word width in bits
//   BE_W    : byte-enable width (one bit per byte of a word)
package d_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = 4;

endpackage

// File: rtl/d_mem_array.sv
// d_mem_array
//   Single-port synchronous RAM of 2**DEPTH_LOG2 x 32-bit words with per-byte
//   write enables. A read issued together with a write returns the new word.
// Ports
//   clock  in   rising-edge clock
//   en     in   access enable; rdata and the array only change when en=1
//   we     in   byte write enables, we[i] writes bits 8i+7:8i
//   addr   in   word index
//   wdata  in   store data
//   rdata  out  registered read data (holds while en=0)
module d_mem_array
   import d_mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic                  clock,
   input  logic                  en,
   input  logic [BE_W-1:0]       we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WORD_W-1:0]     wdata,
   output logic [WORD_W-1:0]     rdata
);

   logic [WORD_W-1:0] mem [2**DEPTH_LOG2];
   logic [WORD_W-1:0] merged;

   // Byte-merge the addressed word so the same value feeds both the array
   // write and the read port (read-during-write returns new data).
   always_comb begin
      merged = mem[addr];
      for (int unsigned i = 0; i < BE_W; i++) begin
         if (we[i]) begin
            merged[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (en) begin
         mem[addr] <= merged;
         rdata     <= merged;
      end
   end

endmodule

// File: rtl/d_mem_responder.sv
// d_mem_responder
//   Memory-side responder for the core's data-memory port. Accepts one word
//   load/store at a time over a valid/ready channel and answers with a single
//   rsp_valid pulse WAIT_CYCLES+1 cycles after the accept edge.
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle (IDLE only)
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_be     in   store byte enables
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  load data; 0 for stores and errors; holds between pulses
//   rsp_err    out  misaligned / out-of-range access; holds between pulses
module d_mem_responder
   import d_mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2  = 8,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam logic [32:0] LIMIT = 33'd4 << DEPTH_LOG2;

   state_t state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic accept;

   logic              lat_write;
   logic [31:0]       lat_addr;
   logic [WORD_W-1:0] lat_wdata;
   logic [BE_W-1:0]   lat_be;

   logic              acc_write;
   logic [31:0]       acc_addr;
   logic [WORD_W-1:0] acc_wdata;
   logic [BE_W-1:0]   acc_be;
   logic [31:0]       offset;
   logic              acc_err;
   logic              enter_resp;

   logic              ram_en;
   logic [BE_W-1:0]   ram_we;
   logic [WORD_W-1:0] ram_rdata;
   logic              rsp_zero;

   // With WAIT_CYCLES==0 the commit edge is the accept edge, so the live
   // request fields are used while still in IDLE; otherwise the latched copy.
   always_comb begin
      if (state == IDLE) begin
         acc_write = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end else begin
         acc_write = lat_write;
         acc_addr  = lat_addr;
         acc_wdata = lat_wdata;
         acc_be    = lat_be;
      end
   end

   // Unsigned subtraction wraps addresses below BASE_ADDR into the error range.
   assign offset  = acc_addr - BASE_ADDR;
   assign acc_err = (offset[1:0] != 2'b00) || ({1'b0, offset} >= LIMIT);

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      req_ready = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nx = RESP;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nx = RESP;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // RESP is only ever entered from IDLE/WAIT, so this marks the commit edge.
   // Gating with reset aborts the access when reset lands on that edge.
   assign enter_resp = (state_nx == RESP) && reset;
   assign ram_en     = enter_resp && !acc_err;
   assign ram_we     = acc_write ? acc_be : '0;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         rsp_err   <= 1'b0;
         rsp_zero  <= 1'b1;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
         end
         if (enter_resp) begin
            rsp_err  <= acc_err;
            rsp_zero <= acc_err || acc_write;
         end
      end
   end

   // The RAM read port only updates on a committed load/store, so the
   // response data naturally holds between pulses; rsp_zero masks stores,
   // errors and the post-reset value.
   assign rsp_rdata = rsp_zero ? '0 : ram_rdata;
   assign rsp_valid = (state == RESP);

   d_mem_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .clock (clock),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (offset[DEPTH_LOG2+1:2]),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_d_mem_responder.sv
module tb_d_mem_responder;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;

   logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_err0;
   logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
   logic [3:0]  req_be0;

   logic        req_valid1, req_ready1, req_write1, rsp_valid1, rsp_err1;
   logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
   logic [3:0]  req_be1;

   int checks = 0;
   int errors = 0;

   d_mem_responder #(
      .DEPTH_LOG2  (8),
      .WAIT_CYCLES (2),
      .BASE_ADDR   (32'h0000_0000)
   ) dut0 (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid0),
      .req_ready (req_ready0),
      .req_write (req_write0),
      .req_addr  (req_addr0),
      .req_wdata (req_wdata0),
      .req_be    (req_be0),
      .rsp_valid (rsp_valid0),
      .rsp_rdata (rsp_rdata0),
      .rsp_err   (rsp_err0)
   );

   d_mem_responder #(
      .DEPTH_LOG2  (8),
      .WAIT_CYCLES (0),
      .BASE_ADDR   (32'h0000_0000)
   ) dut1 (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid1),
      .req_ready (req_ready1),
      .req_write (req_write1),
      .req_addr  (req_addr1),
      .req_wdata (req_wdata1),
      .req_be    (req_be1),
      .rsp_valid (rsp_valid1),
      .rsp_rdata (rsp_rdata1),
      .rsp_err   (rsp_err1)
   );

   task automatic drive(input int sel, input logic v, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      if (sel == 0) begin
         req_valid0 = v; req_write0 = w; req_addr0 = a; req_wdata0 = d; req_be0 = b;
      end else begin
         req_valid1 = v; req_write1 = w; req_addr1 = a; req_wdata1 = d; req_be1 = b;
      end
   endtask

   function automatic logic rdy(input int sel);
      return (sel == 0) ? req_ready0 : req_ready1;
   endfunction

   function automatic logic vld(input int sel);
      return (sel == 0) ? rsp_valid0 : rsp_valid1;
   endfunction

   // One request: wait for ready, accept, release valid, then count cycles to
   // the response. lat = 1 means rsp_valid is already high right after the
   // accept edge.
   task automatic txn(input int sel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rd, output logic er, output int lat);
      int n;
      @(negedge clock);
      drive(sel, 1'b1, wr, addr, wd, be);
      n = 0;
      while (!rdy(sel) && n < 20) begin
         @(negedge clock);
         n++;
      end
      @(posedge clock);
      #1;
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      lat = 1;
      while (!vld(sel) && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      rd = (sel == 0) ? rsp_rdata0 : rsp_rdata1;
      er = (sel == 0) ? rsp_err0 : rsp_err1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready0); end
      checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid0); end
      checks++; if (rsp_rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 00000000", rsp_rdata0); end
      checks++; if (rsp_err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", rsp_err0); end
      checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b exp 1", req_ready1); end
   endtask

   task automatic test_store_load;
      logic [31:0] rd; logic er; int lat;
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d exp 3", lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err got %b exp 0", er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata got %h exp 00000000", rd); end
      @(posedge clock); #1;
      checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL store_pulse_width got %b exp 0", rsp_valid0); end
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d exp 3", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err got %b exp 0", er); end
      @(posedge clock); #1;
      checks++; if (rsp_rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold got %h exp deadbeef", rsp_rdata0); end
   endtask

   task automatic test_byte_enable;
      logic [31:0] rd; logic er; int lat;
      txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be_0001 got %h exp deadbeaa", rd); end
      txn(0, 1'b1, 32'h10, 32'h12345678, 4'b0000, rd, er, lat);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL be_0000_err got %b exp 0", er); end
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be_0000_word got %h exp deadbeaa", rd); end
      txn(0, 1'b1, 32'h10, 32'h11223344, 4'b1010, rd, er, lat);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'h11AD33AA) begin errors++; $display("FAIL be_1010 got %h exp 11ad33aa", rd); end
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic er; int lat;
      txn(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_load_err got %b exp 1", er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_load_rdata got %h exp 00000000", rd); end
      txn(0, 1'b1, 32'h12, 32'h0, 4'hF, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_store_err got %b exp 1", er); end
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'h11AD33AA) begin errors++; $display("FAIL misalign_store_word got %h exp 11ad33aa", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_clears got %b exp 0", er); end
      txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
      txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_store_err got %b exp 1", er); end
      txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL range_word0 got %h exp cafef00d", rd); end
      txn(0, 1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF, rd, er, lat);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_err got %b exp 0", er); end
      txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'h0BADCAFE) begin errors++; $display("FAIL last_word got %h exp 0badcafe", rd); end
      txn(0, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL high_addr_err got %b exp 1", er); end
   endtask

   task automatic test_back_to_back;
      int acc[$];
      int pulses;
      int n;
      pulses = 0;
      @(negedge clock);
      n = 0;
      while (!req_ready0 && n < 20) begin
         @(negedge clock);
         n++;
      end
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      for (int c = 0; c < 17; c++) begin
         if (req_ready0) acc.push_back(c);
         @(posedge clock);
         #1;
         if (rsp_valid0) begin
            pulses++;
            checks++; if (rsp_rdata0 !== 32'h11AD33AA) begin errors++; $display("FAIL b2b_rdata got %h exp 11ad33aa", rsp_rdata0); end
         end
         @(negedge clock);
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (4) begin
         @(posedge clock);
         #1;
         if (rsp_valid0) pulses++;
      end
      checks++; if (acc.size() !== 5) begin errors++; $display("FAIL b2b_accepts got %0d exp 5", acc.size()); end
      for (int i = 0; i < acc.size(); i++) begin
         checks++; if (acc[i] !== 4 * i) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", acc[i], 4 * i); end
      end
      checks++; if (pulses !== 5) begin errors++; $display("FAIL b2b_pulses got %0d exp 5", pulses); end
   endtask

   task automatic test_reset_abort;
      logic [31:0] rd; logic er; int lat;
      int n;
      logic seen;
      txn(0, 1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, lat);
      @(negedge clock);
      drive(0, 1'b1, 1'b1, 32'h20, 32'h22222222, 4'hF);
      n = 0;
      while (!req_ready0 && n < 20) begin
         @(negedge clock);
         n++;
      end
      @(posedge clock);
      #1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      seen = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      if (rsp_valid0) seen = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      repeat (4) begin
         @(posedge clock);
         #1;
         if (rsp_valid0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_pulse got %b exp 0", seen); end
      checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", req_ready0); end
      txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL abort_word got %h exp 11111111", rd); end
   endtask

   task automatic test_zero_wait;
      logic [31:0] rd; logic er; int lat;
      txn(1, 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, rd, er, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL zw_store_latency got %0d exp 1", lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL zw_store_err got %b exp 0", er); end
      txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL zw_load_latency got %0d exp 1", lat); end
      checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL zw_load_rdata got %h exp 5a5a5a5a", rd); end
      txn(1, 1'b0, 32'h401, 32'h0, 4'h0, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL zw_err got %b exp 1", er); end
   endtask

   initial begin
      test_reset;
      test_store_load;
      test_byte_enable;
      test_errors;
      test_back_to_back;
      test_reset_abort;
      test_zero_wait;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
